window_gen: RTL and testbench
=============================

# window_gen

Parametrised multi-channel sliding-window generator with stride and valid/ready flow control. It accepts a raster-ordered pixel stream, one pixel of CH channels per beat. It emits every KY×KX window whose anchor lands on the stride grid, marking the last window of each frame. It sits between the pixel source and the convolution datapath, and replaces the fixed single-channel, stride-1, no-backpressure window stage.

## Interface
- I_F_BW, 8, bits per channel sample
- CH, 1, channels per pixel (≥1)
- IX, 28, frame width in pixels (≥KX)
- IY, 28, frame height in pixels (≥KY)
- KX, 5, window width (≥1)
- KY, 5, window height (≥1)
- STRIDE, 1, window step in both axes (≥1)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all control state
- i_clear  in  1  synchronous frame restart; same effect as reset on control state
- i_in_valid  in  1  input beat valid
- i_in_ready  out  1  input beat accepted when i_in_valid && i_in_ready
- i_in_pixel  in  CH*I_F_BW  channel c at [c*I_F_BW +: I_F_BW]
- o_window_valid  out  1  window valid
- i_out_ready  in  1  downstream ready
- o_window  out  KY*KX*CH*I_F_BW  sample (ky,kx,c) at [((ky*KX+kx)*CH+c)*I_F_BW +: I_F_BW]; ky=0 is the top (oldest) row, kx=0 is the leftmost column
- o_last  out  1  qualifies the last window of the frame; valid only with o_window_valid

## Operation
- Storage:
  - KY-1 line buffers of IX×CH samples.
  - A KY×KX×CH window shift register.
  - Line buffer contents are never reset and need no reset.
- On each accepted beat at position (x,y):
  - Form a column: rows 0..KY-2 come from line buffers 0..KY-2 at address x; row KY-1 is i_in_pixel.
  - Shift the window register left by one column and insert the new column at kx=KX-1.
  - Write the column rows 1..KY-1 into line buffers 0..KY-2 at address x.
  - Advance x. At x=IX-1, wrap x to 0 and advance y. At y=IY-1 with x=IX-1, wrap both to 0 (next frame).
- Window emit condition on the accepted beat, evaluated with the pre-increment x and y:
  - x ≥ KX-1, and
  - y ≥ KY-1, and
  - (x-(KX-1)) mod STRIDE == 0, and
  - (y-(KY-1)) mod STRIDE == 0.
- Stride phase is tracked by per-axis phase counters, reset at x=KX-1 and y=KY-1. No divider is used.
- Stale columns from the previous row never appear in an emitted window; the x ≥ KX-1 gate guarantees this.
- o_last is set with the window whose anchor is the last stride-grid position in the frame, i.e. the largest qualifying (x,y).
- Window count per frame is OX·OY:
  - OX = (IX-KX)/STRIDE+1
  - OY = (IY-KY)/STRIDE+1
  - Integer division; trailing pixels off the stride grid produce no window.
- o_window is driven directly from the window shift register. It is stable while o_window_valid && !i_out_ready.
- i_clear or reset mid-frame:
  - x, y and the phase counters go to 0; o_window_valid and o_last go to 0.
  - The next accepted beat is pixel (0,0) of a new frame.
  - A pending window is discarded.

## Timing
- Reset values:
  - o_window_valid = 0, o_last = 0.
  - i_in_ready = 1 (follows from o_window_valid = 0).
  - o_window contents are don't-care.
- i_in_ready = !o_window_valid || i_out_ready. This is combinational, and is the only combinational path from output to input.
- Latency: o_window_valid rises on the clock edge that accepts the completing pixel, so the window is visible in the following cycle.
- Throughput: 1 beat per cycle, and 1 window per cycle when emitting.
- o_window_valid:
  - set on an accepted beat that meets the emit condition;
  - cleared on the output handshake unless the same-cycle accepted beat emits again (back-to-back).
- Output stalled (o_window_valid && !i_out_ready): no beat is accepted, and the counters, line buffers and window register hold.
- i_in_valid low: state holds; a pending window stays valid.
- Frame boundary: the first beat of frame N+1 is accepted in the same cycle the last window of frame N is consumed. No bubble is required.
- reset asserted at any time: outputs reach their reset values asynchronously.
- i_clear takes effect at the clock edge; an input beat in the same cycle is ignored.

## Test plan
- IX=IY=6, KX=KY=3, STRIDE=1, CH=1, pixel=y*6+x, continuous valid, ready=1:
  - 16 windows are produced.
  - The first window is visible the cycle after pixel 14 is accepted and holds {0,1,2,6,7,8,12,13,14}.
  - o_last is set only on the 16th window, {21,22,23,27,28,29,33,34,35}.
- IX=IY=7, KX=KY=3, STRIDE=2:
  - 9 windows are produced.
  - Anchors are x,y ∈ {2,4,6}.
  - The second window is {2,3,4,9,10,11,16,17,18}.
- CH=3, channels = {v, v+64, v+128}: every window sample (ky,kx,c) sits at the documented bit offset, and the channels are never mixed.
- Random i_out_ready (50%) with random i_in_valid:
  - The window sequence is identical to the ready=1 run.
  - o_window is stable while stalled.
  - No beat is accepted while i_in_ready=0.
- Two back-to-back frames with the output always ready:
  - The second frame yields the same windows as the first.
  - There is no bubble at the frame seam.
  - o_last appears exactly twice.
- Reset asserted after pixel 20, and separately i_clear asserted after pixel 20, each followed by a full frame: outputs are 0 immediately, and the full frame then yields exactly the baseline 16 windows.

Source files
------------

// File: rtl/window_gen_if.sv
// Pixel-in / window-out stream bundle for window_gen; the source and sink drive the master side.
interface window_gen_if #(
    parameter int I_F_BW = 8,
    parameter int CH     = 1,
    parameter int KX     = 5,
    parameter int KY     = 5
);
    logic                           i_in_valid;
    logic                           i_in_ready;
    logic [CH*I_F_BW-1:0]           i_in_pixel;
    logic                           o_window_valid;
    logic                           i_out_ready;
    logic [KY*KX*CH*I_F_BW-1:0]     o_window;
    logic                           o_last;

    modport master (
        output i_in_valid, i_in_pixel, i_out_ready,
        input  i_in_ready, o_window_valid, o_window, o_last
    );

    modport slave (
        input  i_in_valid, i_in_pixel, i_out_ready,
        output i_in_ready, o_window_valid, o_window, o_last
    );
endinterface

// File: rtl/window_gen.sv
// Strided KYxKX multi-channel sliding-window generator over a raster pixel stream.
// Window valid the cycle after its completing pixel; a stalled window freezes all state and blocks input.
module window_gen #(
    parameter int I_F_BW = 8,
    parameter int CH     = 1,
    parameter int IX     = 28,
    parameter int IY     = 28,
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int STRIDE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    window_gen_if.slave bus
);
    localparam int PW     = CH * I_F_BW;
    localparam int XW     = (IX > 1) ? $clog2(IX) : 1;
    localparam int YW     = (IY > 1) ? $clog2(IY) : 1;
    localparam int SW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int LB     = (KY > 1) ? KY - 1 : 1;
    localparam int X_ANCH = KX - 1 + ((IX - KX) / STRIDE) * STRIDE;
    localparam int Y_ANCH = KY - 1 + ((IY - KY) / STRIDE) * STRIDE;

    localparam logic [XW-1:0] X_MAX   = XW'(IX - 1);
    localparam logic [XW-1:0] X_FIRST = XW'(KX - 1);
    localparam logic [XW-1:0] X_END   = XW'(X_ANCH);
    localparam logic [YW-1:0] Y_MAX   = YW'(IY - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(KY - 1);
    localparam logic [YW-1:0] Y_END   = YW'(Y_ANCH);
    localparam logic [SW-1:0] S_MAX   = SW'(STRIDE - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [SW-1:0] px;
    logic [SW-1:0] py;
    logic          win_vld;
    logic          win_last;
    logic          accept;
    logic          emit;
    logic          x_wrap;
    logic          y_wrap;

    logic [PW-1:0] lb  [LB][IX];
    logic [PW-1:0] win [KY][KX];
    logic [PW-1:0] col [KY];

    assign bus.i_in_ready     = !win_vld || bus.i_out_ready;
    assign bus.o_window_valid = win_vld;
    assign bus.o_last         = win_last;

    // A clear cycle swallows any beat presented alongside it.
    assign accept = bus.i_in_valid && bus.i_in_ready && !i_clear;
    assign x_wrap = (x == X_MAX);
    assign y_wrap = (y == Y_MAX);
    assign emit   = (x >= X_FIRST) && (y >= Y_FIRST) && (px == '0) && (py == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            px       <= '0;
            py       <= '0;
            win_vld  <= 1'b0;
            win_last <= 1'b0;
        end else if (i_clear) begin
            x        <= '0;
            y        <= '0;
            px       <= '0;
            py       <= '0;
            win_vld  <= 1'b0;
            win_last <= 1'b0;
        end else if (accept) begin
            win_vld  <= emit;
            win_last <= emit && (x == X_END) && (y == Y_END);
            x        <= x_wrap ? '0 : x + 1'b1;
            // Phase stays 0 until the first full-width column, then cycles through the stride.
            px       <= (x_wrap || x < X_FIRST || px == S_MAX) ? '0 : px + 1'b1;
            if (x_wrap) begin
                y  <= y_wrap ? '0 : y + 1'b1;
                py <= (y_wrap || y < Y_FIRST || py == S_MAX) ? '0 : py + 1'b1;
            end
        end else if (bus.i_out_ready) begin
            win_vld  <= 1'b0;
            win_last <= 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < KY - 1; k++) begin
            col[k] = lb[k][x];
        end
        col[KY-1] = bus.i_in_pixel;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < KY - 1; k++) begin
                lb[k][x] <= col[k+1];
            end
            for (int r = 0; r < KY; r++) begin
                for (int c = 0; c < KX - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][KX-1] <= col[r];
            end
        end
    end

    for (genvar r = 0; r < KY; r++) begin : g_row
        for (genvar c = 0; c < KX; c++) begin : g_col
            assign bus.o_window[(r*KX+c)*PW +: PW] = win[r][c];
        end
    end
endmodule

// File: tb/tb_window_gen.sv
`timescale 1ns/1ps
module tb_window_gen;
    typedef struct {int x; int y;} anc_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic a_clr = 1'b0;
    logic a_rnd = 1'b0;
    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference-model state: anchors still owed by each DUT, and observed windows (channel 0).
    anc_t aq[$];
    anc_t bq[$];
    logic [71:0] a_seen[$];
    logic [71:0] a_base[$];
    logic [71:0] b_seen[$];
    int a_wins = 0, a_lasts = 0, a_lat = -1, a_last_idx = -1, a_stalls = 0;
    int b_wins = 0, b_lasts = 0, b_last_idx = -1;

    always #5 clk = ~clk;

    window_gen_if #(.I_F_BW(8), .CH(3), .KX(3), .KY(3)) a_if ();
    window_gen_if #(.I_F_BW(8), .CH(1), .KX(3), .KY(3)) b_if ();

    window_gen #(.I_F_BW(8), .CH(3), .IX(6), .IY(6), .KX(3), .KY(3), .STRIDE(1)) dut_a (
        .clk(clk), .reset(rst), .i_clear(a_clr), .bus(a_if));
    window_gen #(.I_F_BW(8), .CH(1), .IX(7), .IY(7), .KX(3), .KY(3), .STRIDE(2)) dut_b (
        .clk(clk), .reset(rst), .i_clear(1'b0), .bus(b_if));

    task automatic chk(input string name, input logic [215:0] act, input logic [215:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] mk9(input int s0, s1, s2, s3, s4, s5, s6, s7, s8);
        logic [71:0] r;
        r = {8'(s8), 8'(s7), 8'(s6), 8'(s5), 8'(s4), 8'(s3), 8'(s2), 8'(s1), 8'(s0)};
        return r;
    endfunction

    function automatic bit is_anchor(input int x, input int y, input int s);
        return x >= 2 && y >= 2 && (x - 2) % s == 0 && (y - 2) % s == 0;
    endfunction

    // Last window: no further grid anchor fits to the right or below in an n x n frame.
    function automatic bit is_final(input int ax, input int ay, input int n, input int s);
        return (ax + s > n - 1) && (ay + s > n - 1);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        a_if.i_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_if.i_out_ready = a_rnd ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    initial begin : a_cmp
        anc_t e;
        logic [215:0] exp;
        logic [215:0] hold;
        logic [71:0] s;
        bit hold_vld;
        int ax, ay, acc;
        hold_vld = 0; ax = 0; ay = 0; acc = 0; hold = '0;
        forever begin
            @(negedge clk);
            if (rst || a_clr) begin
                aq.delete(); ax = 0; ay = 0; acc = 0; hold_vld = 0;
            end else begin
                chk("a_in_ready_rule", a_if.i_in_ready, !a_if.o_window_valid || a_if.i_out_ready);
                chk("a_last_qualified", a_if.o_last && !a_if.o_window_valid, 0);
                if (a_if.o_window_valid) begin
                    if (a_lat < 0) a_lat = acc;
                    if (hold_vld) chk("a_stall_stable", a_if.o_window, hold);
                    if (a_if.i_out_ready) begin
                        hold_vld = 0;
                        chk("a_window_expected", aq.size() > 0, 1);
                        if (aq.size() > 0) begin
                            e = aq.pop_front();
                            exp = '0;
                            for (int ky = 0; ky < 3; ky++)
                                for (int kx = 0; kx < 3; kx++)
                                    for (int c = 0; c < 3; c++)
                                        exp[((ky*3+kx)*3+c)*8 +: 8] = 8'((e.y-2+ky)*6 + e.x-2+kx + 64*c);
                            chk("a_window", a_if.o_window, exp);
                            chk("a_last", a_if.o_last, is_final(e.x, e.y, 6, 1));
                        end
                        for (int k = 0; k < 9; k++) s[k*8 +: 8] = a_if.o_window[k*24 +: 8];
                        a_seen.push_back(s);
                        if (a_if.o_last) a_last_idx = a_seen.size() - 1;
                        a_wins++;
                        a_lasts += int'(a_if.o_last);
                    end else begin
                        hold = a_if.o_window;
                        hold_vld = 1;
                        a_stalls++;
                    end
                end
                if (a_if.i_in_valid && a_if.i_in_ready) begin
                    if (is_anchor(ax, ay, 1)) aq.push_back('{ax, ay});
                    acc++;
                    if (ax == 5) begin ax = 0; ay = (ay == 5) ? 0 : ay + 1; end
                    else ax++;
                end
            end
        end
    end

    initial begin : b_cmp
        anc_t e;
        logic [71:0] exp;
        int bx, by;
        bx = 0; by = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bq.delete(); bx = 0; by = 0;
            end else begin
                if (b_if.o_window_valid && b_if.i_out_ready) begin
                    chk("b_window_expected", bq.size() > 0, 1);
                    if (bq.size() > 0) begin
                        e = bq.pop_front();
                        for (int ky = 0; ky < 3; ky++)
                            for (int kx = 0; kx < 3; kx++)
                                exp[(ky*3+kx)*8 +: 8] = 8'((e.y-2+ky)*7 + e.x-2+kx);
                        chk("b_window", b_if.o_window, exp);
                        chk("b_last", b_if.o_last, is_final(e.x, e.y, 7, 2));
                    end
                    b_seen.push_back(b_if.o_window);
                    if (b_if.o_last) b_last_idx = b_seen.size() - 1;
                    b_wins++;
                    b_lasts += int'(b_if.o_last);
                end
                if (b_if.i_in_valid && b_if.i_in_ready) begin
                    if (is_anchor(bx, by, 2)) bq.push_back('{bx, by});
                    if (bx == 6) begin bx = 0; by = (by == 6) ? 0 : by + 1; end
                    else bx++;
                end
            end
        end
    end

    task automatic a_send(input int v);
        int t;
        if (a_rnd) begin
            while ($urandom_range(1) == 0) begin
                a_if.i_in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        a_if.i_in_valid = 1'b1;
        a_if.i_in_pixel = {8'(v + 128), 8'(v + 64), 8'(v)};
        t = 0;
        @(negedge clk);
        while (!a_if.i_in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("a_send_timeout", t, 0);
        @(posedge clk);
        #1;
        a_if.i_in_valid = 1'b0;
    endtask

    task automatic b_send(input int v);
        int t;
        b_if.i_in_valid = 1'b1;
        b_if.i_in_pixel = 8'(v);
        t = 0;
        @(negedge clk);
        while (!b_if.i_in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("b_send_timeout", t, 0);
        @(posedge clk);
        #1;
        b_if.i_in_valid = 1'b0;
    endtask

    task automatic a_frame();
        for (int i = 0; i < 36; i++) a_send(i);
    endtask

    task automatic a_drain();
        int t;
        t = 0;
        while (a_if.o_window_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("a_drain_bounded", t < 500, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, l0, c0;
        a_if.i_in_valid = 1'b0;
        a_if.i_in_pixel = '0;
        b_if.i_in_valid = 1'b0;
        b_if.i_in_pixel = '0;
        b_if.i_out_ready = 1'b1;
        #12;
        chk("rst_a_valid", a_if.o_window_valid, 0);
        chk("rst_a_last", a_if.o_last, 0);
        chk("rst_a_in_ready", a_if.i_in_ready, 1);
        chk("rst_b_valid", b_if.o_window_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stride-2 frame: anchors at x,y in {2,4,6}.
        for (int i = 0; i < 49; i++) b_send(i);
        repeat (3) @(posedge clk);
        #1;
        chk("b_count", b_wins, 9);
        chk("b_lasts", b_lasts, 1);
        chk("b_last_idx", b_last_idx, 8);
        chk("b_first", b_seen[0], mk9(0, 1, 2, 7, 8, 9, 14, 15, 16));
        chk("b_second", b_seen[1], mk9(2, 3, 4, 9, 10, 11, 16, 17, 18));
        chk("b_ninth", b_seen[8], mk9(32, 33, 34, 39, 40, 41, 46, 47, 48));
        chk("b_queue_empty", bq.size(), 0);

        // Baseline frame, continuous valid, always ready.
        a_seen.delete(); w0 = a_wins; l0 = a_lasts;
        a_frame();
        a_drain();
        chk("a_base_count", a_wins - w0, 16);
        chk("a_base_lasts", a_lasts - l0, 1);
        chk("a_first_latency", a_lat, 15);
        chk("a_first_window", a_seen[0], mk9(0, 1, 2, 6, 7, 8, 12, 13, 14));
        chk("a_16th_window", a_seen[15], mk9(21, 22, 23, 27, 28, 29, 33, 34, 35));
        chk("a_last_idx", a_last_idx, 15);
        chk("a_queue_empty", aq.size(), 0);
        a_base = a_seen;

        // Random valid and random downstream ready.
        a_seen.delete(); a_stalls = 0; a_rnd = 1'b1;
        a_frame();
        a_drain();
        a_rnd = 1'b0;
        @(posedge clk);
        #1;
        chk("a_rand_count", a_seen.size(), 16);
        for (int i = 0; i < 16 && i < a_seen.size(); i++) chk("a_rand_seq", a_seen[i], a_base[i]);
        chk("a_rand_had_stalls", a_stalls > 0, 1);

        // Two frames back to back: no bubble at the seam.
        a_seen.delete(); w0 = a_wins; l0 = a_lasts; c0 = cyc;
        a_frame();
        a_frame();
        chk("a_seam_cycles", cyc - c0, 72);
        a_drain();
        chk("a_b2b_count", a_wins - w0, 32);
        chk("a_b2b_lasts", a_lasts - l0, 2);
        for (int i = 0; i < 16 && i + 16 < a_seen.size(); i++) chk("a_b2b_repeat", a_seen[i+16], a_seen[i]);

        // Asynchronous reset with a window pending.
        for (int i = 0; i < 21; i++) a_send(i);
        chk("a_pending_before_reset", a_if.o_window_valid, 1);
        rst = 1'b1;
        #1;
        chk("a_reset_valid", a_if.o_window_valid, 0);
        chk("a_reset_last", a_if.o_last, 0);
        chk("a_reset_in_ready", a_if.i_in_ready, 1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        w0 = a_wins; l0 = a_lasts;
        a_frame();
        a_drain();
        chk("a_post_reset_count", a_wins - w0, 16);
        chk("a_post_reset_lasts", a_lasts - l0, 1);

        // Synchronous clear with a beat offered in the same cycle.
        for (int i = 0; i < 21; i++) a_send(i);
        chk("a_pending_before_clear", a_if.o_window_valid, 1);
        a_clr = 1'b1;
        a_if.i_in_valid = 1'b1;
        a_if.i_in_pixel = {8'd99, 8'd99, 8'd99};
        @(posedge clk);
        #1;
        a_clr = 1'b0;
        a_if.i_in_valid = 1'b0;
        chk("a_clear_valid", a_if.o_window_valid, 0);
        chk("a_clear_last", a_if.o_last, 0);
        w0 = a_wins; l0 = a_lasts;
        a_frame();
        a_drain();
        chk("a_post_clear_count", a_wins - w0, 16);
        chk("a_post_clear_lasts", a_lasts - l0, 1);
        chk("a_final_queue_empty", aq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
